// File: rtl/led_pkg.sv
// Shared definitions for the one-hot LED sequencer: mode encodings and
// the pin-polarity helper.
package led_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_DIRECT = 2'b00;
   localparam mode_t MODE_UP     = 2'b01;
   localparam mode_t MODE_DOWN   = 2'b10;
   localparam mode_t MODE_BOUNCE = 2'b11;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Pin level for one LED given whether it should be lit.
   function automatic logic led_level(input logic lit, input logic active_low);
      return lit ^ active_low;
   endfunction

endpackage

// File: rtl/led_prescaler.sv
// Chase-step prescaler: counts 0..tickDiv while enabled and pulses tick on
// the terminal count; clr forces the count back to 0 with no tick.
module led_prescaler #(
   parameter int DIV_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [DIV_W-1:0] tickDiv,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   // >= rather than == so a count stranded above a shrunk tickDiv terminates.
   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         if (cnt_q >= tickDiv) begin
            cnt_d = '0;
            tick  = 1'b1;
         end else begin
            cnt_d = cnt_q + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/led_onehot_sequencer.sv
// One-hot LED driver: direct index display or self-running chase/bounce,
// with enable blanking, out-of-range flag and selectable pin polarity.
module led_onehot_sequencer
   import led_pkg::*;
#(
   parameter int SEL_W      = 3,
   parameter int N_OUT      = 8,
   parameter int DIV_W      = 24,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [SEL_W-1:0] codeIn,
   input  logic [DIV_W-1:0] tickDiv,
   output logic [N_OUT-1:0] ledOut,
   output logic [SEL_W-1:0] curIdx,
   output logic             wrapPulse,
   output logic             errFlag
);

   localparam logic [SEL_W-1:0] LAST    = SEL_W'(N_OUT - 1);
   localparam logic [N_OUT-1:0] LED_OFF = ACTIVE_LOW ? '1 : '0;

   logic [SEL_W-1:0] cur_idx_q, cur_idx_d;
   logic             dir_q, dir_d;
   mode_t            prev_mode_q;
   logic [N_OUT-1:0] led_q, led_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;

   logic mode_chg, presc_clr, tick, code_oor, show;

   assign mode_chg  = (mode != prev_mode_q);
   assign presc_clr = mode_chg || (mode == MODE_DIRECT);
   assign code_oor  = (32'(codeIn) >= N_OUT);

   led_prescaler #(.DIV_W(DIV_W)) u_presc (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .clr     (presc_clr),
      .tickDiv (tickDiv),
      .tick    (tick)
   );

   // tick is suppressed on a mode-change cycle, so the chase arms below only
   // ever step from cur_idx_q in a steady mode.
   always_comb begin
      cur_idx_d = cur_idx_q;
      dir_d     = dir_q;
      wrap_d    = 1'b0;
      err_d     = 1'b0;

      if (mode_chg) begin
         if (cur_idx_q > LAST) cur_idx_d = '0;
         dir_d = (cur_idx_d == LAST) ? DIR_DOWN : DIR_UP;
      end

      case (mode)
         MODE_DIRECT: begin
            err_d = code_oor;
            if (en && !code_oor) cur_idx_d = codeIn;
         end
         MODE_UP: begin
            if (tick) begin
               if (cur_idx_q == LAST) begin
                  cur_idx_d = '0;
                  wrap_d    = 1'b1;
               end else begin
                  cur_idx_d = cur_idx_q + SEL_W'(1);
               end
            end
         end
         MODE_DOWN: begin
            if (tick) begin
               if (cur_idx_q == '0) begin
                  cur_idx_d = LAST;
                  wrap_d    = 1'b1;
               end else begin
                  cur_idx_d = cur_idx_q - SEL_W'(1);
               end
            end
         end
         default: begin
            if (tick) begin
               if (dir_q == DIR_UP) begin
                  if (cur_idx_q == LAST) begin
                     cur_idx_d = LAST - SEL_W'(1);
                     dir_d     = DIR_DOWN;
                     wrap_d    = 1'b1;
                  end else begin
                     cur_idx_d = cur_idx_q + SEL_W'(1);
                  end
               end else begin
                  if (cur_idx_q == '0) begin
                     cur_idx_d = SEL_W'(1);
                     dir_d     = DIR_UP;
                     wrap_d    = 1'b1;
                  end else begin
                     cur_idx_d = cur_idx_q - SEL_W'(1);
                  end
               end
            end
         end
      endcase
   end

   // LED register is loaded from next-state so ledOut always matches curIdx.
   assign show = en && !err_d;

   for (genvar g = 0; g < N_OUT; g++) begin : g_led
      assign led_d[g] = led_level(show && (cur_idx_d == SEL_W'(g)), ACTIVE_LOW);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_idx_q   <= '0;
         dir_q       <= DIR_UP;
         prev_mode_q <= MODE_DIRECT;
         led_q       <= LED_OFF;
         wrap_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         cur_idx_q   <= cur_idx_d;
         dir_q       <= dir_d;
         prev_mode_q <= mode;
         led_q       <= led_d;
         wrap_q      <= wrap_d;
         err_q       <= err_d;
      end
   end

   assign ledOut    = led_q;
   assign curIdx    = cur_idx_q;
   assign wrapPulse = wrap_q;
   assign errFlag   = err_q;

endmodule
